// File: rtl/multi_cell_bus_arbiter_pkg.sv
// Shared encodings for the multi-channel bus arbiter: FSM states, operation type, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multi_cell_bus_arbiter_pkg;

    // Default sizes, kept alongside the width constants used by the rest of the cell array.
    localparam int unsigned ARB_N_CH_DEF    = 4;
    localparam int unsigned ARB_ADDR_W_DEF  = 32;
    localparam int unsigned ARB_DATA_W_DEF  = 32;
    localparam int unsigned ARB_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_XFER  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        ARB_OP_READ  = 1'b0,
        ARB_OP_WRITE = 1'b1
    } arb_op_t;

    // Width of the timeout counter; at least one bit even when the timeout is disabled.
    function automatic int unsigned arb_cnt_w(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/multi_cell_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr_i, wrapping upward.
// Latency: zero cycles (pure combinational).
// Backpressure: none; gnt_vld_o is low when no request is present.
// Ports: req_i request vector, ptr_i last-served index, gnt_idx_o winner, gnt_vld_o winner valid.
module multi_cell_bus_arbiter_rr_pick
    import multi_cell_bus_arbiter_pkg::*;
#(
    parameter int unsigned N_CH  = ARB_N_CH_DEF,
    parameter int unsigned IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_vld_o
);

    always_comb begin
        int unsigned cand;
        cand      = 0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        // Offset 1..N_CH so the last-served channel is considered only after everyone else.
        for (int unsigned k = 1; k <= N_CH; k++) begin
            cand = (int'(ptr_i) + k) % N_CH;
            if (!gnt_vld_o && req_i[cand]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/multi_cell_bus_arbiter.sv
// Arbitrates N_CH cell request channels onto one shared read/write bus with round-robin fairness and timeout.
// Latency: request in IDLE at cycle 0 -> GRANT cycle 1 -> strobe cycle 2; ack at cycle k -> ch_dn at k+1.
// Backpressure: bus_busy_in or halt_q_in hold off new grants; a transfer in flight is never interrupted.
// Ports: ch_* per-channel request side (packed addr/wdata), ch_dn/ch_err/ch_rdata completion,
//        bus_busy_in/out ownership, addr_out/data_out/read_q/write_q bus master side (zero when not owner),
//        data_in/read_dn/write_dn bus slave response, halt_q_in global grant hold-off.
module multi_cell_bus_arbiter
    import multi_cell_bus_arbiter_pkg::*;
#(
    parameter int unsigned N_CH    = ARB_N_CH_DEF,
    parameter int unsigned ADDR_W  = ARB_ADDR_W_DEF,
    parameter int unsigned DATA_W  = ARB_DATA_W_DEF,
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          ch_read_q,
    input  logic [N_CH-1:0]          ch_write_q,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr,
    input  logic [N_CH*DATA_W-1:0]   ch_wdata,
    output logic [N_CH-1:0]          ch_dn,
    output logic [N_CH-1:0]          ch_err,
    output logic [DATA_W-1:0]        ch_rdata,
    input  logic                     halt_q_in,
    input  logic                     bus_busy_in,
    output logic                     bus_busy_out,
    output logic [ADDR_W-1:0]        addr_out,
    output logic [DATA_W-1:0]        data_out,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     read_q,
    output logic                     write_q,
    input  logic                     read_dn,
    input  logic                     write_dn
);

    localparam int unsigned IDX_W   = $clog2(N_CH);
    localparam int unsigned CNT_W   = arb_cnt_w(TIMEOUT);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    arb_state_t          state_q, state_d;
    arb_op_t             op_q, op_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [N_CH-1:0]     req;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_vld;
    logic                start;
    logic                ack;
    logic                expire;
    logic [N_CH-1:0]     idx_oh;

    assign req    = ch_read_q | ch_write_q;
    assign start  = pick_vld && !bus_busy_in && !halt_q_in;
    // Only the acknowledge matching the latched operation counts; the other one is ignored.
    assign ack    = (op_q == ARB_OP_WRITE) ? write_dn : read_dn;
    assign expire = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));
    assign idx_oh = N_CH'(1) << idx_q;

    multi_cell_bus_arbiter_rr_pick #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .gnt_idx_o (pick_idx),
        .gnt_vld_o (pick_vld)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Acknowledge wins over a simultaneous timeout expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (start) state_d = ARB_GRANT;
            ARB_GRANT: state_d = ARB_XFER;
            ARB_XFER:  if (ack || expire) state_d = ARB_DONE;
            ARB_DONE:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Datapath next-state.
    always_comb begin
        op_d    = op_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ARB_IDLE: begin
                if (start) idx_d = pick_idx;
            end
            ARB_GRANT: begin
                // Write takes precedence; a pending read on the same channel is served at a later grant.
                op_d    = ch_write_q[idx_q] ? ARB_OP_WRITE : ARB_OP_READ;
                addr_d  = ch_addr[int'(idx_q) * ADDR_W +: ADDR_W];
                wdata_d = ch_wdata[int'(idx_q) * DATA_W +: DATA_W];
                rdata_d = '0;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            ARB_XFER: begin
                if (ack) begin
                    if (op_q == ARB_OP_READ) rdata_d = data_in;
                end else if (expire) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARB_DONE: begin
                ptr_d = idx_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= ARB_OP_READ;
            idx_q   <= '0;
            ptr_q   <= IDX_W'(N_CH - 1);
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            op_q    <= op_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode from state only, so everything is zero whenever the bus is not owned.
    always_comb begin
        bus_busy_out = (state_q != ARB_IDLE);
        read_q       = (state_q == ARB_XFER) && (op_q == ARB_OP_READ);
        write_q      = (state_q == ARB_XFER) && (op_q == ARB_OP_WRITE);
        addr_out     = (state_q == ARB_XFER) ? addr_q : '0;
        data_out     = write_q ? wdata_q : '0;
        ch_dn        = (state_q == ARB_DONE) ? idx_oh : '0;
        ch_err       = ((state_q == ARB_DONE) && err_q) ? idx_oh : '0;
        ch_rdata     = (state_q == ARB_DONE) ? rdata_q : '0;
    end

endmodule

// File: tb/tb_multi_cell_bus_arbiter.sv
// Self-checking bench for multi_cell_bus_arbiter: vector table plus corner sequences, scoreboard on ch_dn.
// Latency: n/a.
// Backpressure: bus responder acks after a per-transfer delay; 255 means never.
module tb_multi_cell_bus_arbiter;

    localparam int N_CH = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TO   = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_CH-1:0]      ch_read_q, ch_write_q;
    logic [N_CH*AW-1:0]   ch_addr;
    logic [N_CH*DW-1:0]   ch_wdata;
    logic [N_CH-1:0]      ch_dn, ch_err;
    logic [DW-1:0]        ch_rdata;
    logic                 halt_q_in, bus_busy_in, bus_busy_out;
    logic [AW-1:0]        addr_out;
    logic [DW-1:0]        data_out, data_in;
    logic                 read_q, write_q, read_dn, write_dn;

    multi_cell_bus_arbiter #(
        .N_CH(N_CH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_read_q(ch_read_q), .ch_write_q(ch_write_q),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_dn(ch_dn), .ch_err(ch_err), .ch_rdata(ch_rdata),
        .halt_q_in(halt_q_in), .bus_busy_in(bus_busy_in), .bus_busy_out(bus_busy_out),
        .addr_out(addr_out), .data_out(data_out), .data_in(data_in),
        .read_q(read_q), .write_q(write_q), .read_dn(read_dn), .write_dn(write_dn)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          ch;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic        wrong;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_len;
    } vec_t;

    exp_t        sb[$];
    vec_t        vt[7];
    int          n_vec = 0;
    int          n_bad = 0;
    int          ack_dly = 255;
    logic        wrong_ack = 1'b0;
    logic        chk_bus = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_dout = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus slave model: address 0x100 returns DEADBEEF, everything else {~a[15:0], a[15:0]}.
    function automatic logic [31:0] bus_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [63:0] outs();
        return {21'b0, ch_dn, ch_err, bus_busy_out, read_q, write_q, addr_out | data_out | ch_rdata};
    endfunction

    task automatic set_ch(input int ch, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        ch_read_q[ch]         = rd;
        ch_write_q[ch]        = wr;
        ch_addr[ch*AW +: AW]  = a;
        ch_wdata[ch*DW +: DW] = wd;
    endtask

    task automatic push_exp(input int ch, input logic err, input logic [31:0] rd);
        exp_t e;
        e.ch = ch; e.err = err; e.rdata = rd;
        sb.push_back(e);
    endtask

    // Waits (bounded) for ch_dn[ch]; k counts negedges after the request was driven.
    task automatic run_xfer(input int ch, output int len, output int first_s, output int dn_k,
                            output int busy, output logic saw_w, output logic saw_r, output logic [31:0] dout);
        bit done;
        done = 0; len = 0; first_s = -1; dn_k = -1; busy = 0; saw_w = 0; saw_r = 0; dout = '0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (bus_busy_out) busy++;
            if (read_q || write_q) begin
                len++;
                if (first_s < 0) first_s = k;
            end
            if (read_q)  saw_r = 1'b1;
            if (write_q) saw_w = 1'b1;
            dout = dout | data_out;
            if (ch_dn[ch]) begin
                dn_k = k;
                done = 1;
            end
        end
        chk($sformatf("xfer_done_ch%0d", ch), 64'(done), 64'd1);
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t       e;
        logic [3:0] oh;
        forever begin
            @(negedge clk);
            if (ch_dn !== '0 || ch_err !== '0) begin
                if (sb.size() == 0) begin
                    chk("sb_spurious_dn", {56'b0, ch_dn, ch_err}, 64'd0);
                end else begin
                    e  = sb.pop_front();
                    oh = 4'b0001 << e.ch;
                    chk($sformatf("sb_dn_ch%0d", e.ch), 64'(ch_dn), 64'(oh));
                    chk($sformatf("sb_err_ch%0d", e.ch), 64'(ch_err), e.err ? 64'(oh) : 64'd0);
                    chk($sformatf("sb_rdata_ch%0d", e.ch), 64'(ch_rdata), 64'(e.rdata));
                end
            end
        end
    end

    // Bus responder.
    initial begin
        int cnt;
        cnt = 0; read_dn = 1'b0; write_dn = 1'b0; data_in = '0;
        forever begin
            @(negedge clk);
            read_dn  = 1'b0;
            write_dn = 1'b0;
            data_in  = $urandom;
            if (read_q || write_q) begin
                if (cnt == 0 && chk_bus) begin
                    chk("bus_addr", 64'(addr_out), 64'(exp_addr));
                    chk("bus_dout", 64'(data_out), 64'(exp_dout));
                end
                if (ack_dly != 255 && cnt == ack_dly) begin
                    if (read_q) begin
                        read_dn = 1'b1;
                        data_in = bus_fn(addr_out);
                    end else begin
                        write_dn = 1'b1;
                    end
                end else if (wrong_ack && cnt == 0) begin
                    if (read_q) write_dn = 1'b1;
                    else        read_dn  = 1'b1;
                end
                cnt++;
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          len, fs, dk, busy, n_done;
        int          order[5];
        logic        sw, sr;
        logic [31:0] dout;
        logic [63:0] acc;

        rst = 1'b1; ch_read_q = '0; ch_write_q = '0; ch_addr = '0; ch_wdata = '0;
        halt_q_in = 1'b0; bus_busy_in = 1'b0;

        //        ch wr    addr          wdata          dly wrong err   rdata          len
        vt[0] = '{2, 1'b0, 32'h0000_0100, 32'h0,          3, 1'b0, 1'b0, 32'hDEADBEEF, 4};
        vt[1] = '{1, 1'b1, 32'h0000_0200, 32'h1122_3344, 255, 1'b0, 1'b1, 32'h0,        8};
        vt[2] = '{0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5,  0, 1'b0, 1'b0, 32'h0,        1};
        vt[3] = '{3, 1'b0, 32'h0000_03FC, 32'h0,          7, 1'b0, 1'b0, 32'hFC03_03FC, 8};
        vt[4] = '{1, 1'b0, 32'h0000_0080, 32'h0,        255, 1'b0, 1'b1, 32'h0,        8};
        vt[5] = '{2, 1'b1, 32'h0000_00C0, 32'h0BAD_F00D,  2, 1'b1, 1'b0, 32'h0,        3};
        vt[6] = '{0, 1'b0, 32'h0000_0010, 32'h0,          1, 1'b1, 1'b0, 32'hFFEF_0010, 2};

        @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fairness from reset: all channels keep requesting, immediate acks.
        ack_dly = 0; wrong_ack = 1'b0;
        for (int i = 0; i < 5; i++) order[i] = -1;
        for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 1'b0, 32'(32'h1000 + i*16), 32'h0);
        for (int i = 0; i < 5; i++) push_exp(i % 4, 1'b0, bus_fn(32'(32'h1000 + (i % 4)*16)));
        n_done = 0;
        for (int k = 0; k < 60 && n_done < 5; k++) begin
            @(negedge clk);
            if (ch_dn != '0) begin
                for (int c = 0; c < 4; c++) if (ch_dn[c]) order[n_done] = c;
                n_done++;
                if (n_done == 5) ch_read_q = '0;
            end
        end
        chk("fair_count", 64'(n_done), 64'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("fair_order_%0d", i), 64'(order[i]), 64'(i % 4));
        @(negedge clk);

        // Single-transaction vector table.
        foreach (vt[i]) begin
            ack_dly   = vt[i].dly;
            wrong_ack = vt[i].wrong;
            chk_bus   = 1'b1;
            exp_addr  = vt[i].addr;
            exp_dout  = vt[i].wr ? vt[i].wdata : 32'h0;
            push_exp(vt[i].ch, vt[i].exp_err, vt[i].exp_rdata);
            set_ch(vt[i].ch, !vt[i].wr, vt[i].wr, vt[i].addr, vt[i].wdata);
            run_xfer(vt[i].ch, len, fs, dk, busy, sw, sr, dout);
            set_ch(vt[i].ch, 1'b0, 1'b0, vt[i].addr, vt[i].wdata);
            chk($sformatf("v%0d_strobe_len", i), 64'(len), 64'(vt[i].exp_len));
            chk($sformatf("v%0d_first_strobe", i), 64'(fs), 64'd2);
            chk($sformatf("v%0d_dn_cycle", i), 64'(dk), 64'(2 + vt[i].exp_len));
            chk($sformatf("v%0d_busy_cycles", i), 64'(busy), 64'(vt[i].exp_len + 2));
            chk($sformatf("v%0d_op", i), {62'b0, sw, sr}, vt[i].wr ? 64'd2 : 64'd1);
            @(negedge clk);
            chk($sformatf("v%0d_idle_after", i), outs(), 64'd0);
        end
        chk_bus = 1'b0; wrong_ack = 1'b0;

        // Read and write pending on one channel: write first, then the read.
        ack_dly = 1;
        push_exp(3, 1'b0, 32'h0);
        push_exp(3, 1'b0, bus_fn(32'h300));
        set_ch(3, 1'b1, 1'b1, 32'h300, 32'hCAFE_F00D);
        run_xfer(3, len, fs, dk, busy, sw, sr, dout);
        chk("rw_first_is_write", {62'b0, sw, sr}, 64'd2);
        chk("rw_first_dout", 64'(dout), 64'hCAFE_F00D);
        ch_write_q[3] = 1'b0;
        run_xfer(3, len, fs, dk, busy, sw, sr, dout);
        chk("rw_second_is_read", {62'b0, sw, sr}, 64'd1);
        chk("rw_second_dout", 64'(dout), 64'd0);
        ch_read_q[3] = 1'b0;
        @(negedge clk);

        // Grant hold-off by bus_busy_in, then by halt_q_in.
        ack_dly = 0;
        for (int b = 0; b < 2; b++) begin
            acc = '0;
            if (b == 0) bus_busy_in = 1'b1;
            else        halt_q_in   = 1'b1;
            set_ch(0, 1'b1, 1'b0, 32'h20, 32'h0);
            repeat (5) begin
                @(negedge clk);
                acc = acc | outs();
            end
            chk($sformatf("blk%0d_quiet", b), acc, 64'd0);
            bus_busy_in = 1'b0;
            halt_q_in   = 1'b0;
            push_exp(0, 1'b0, bus_fn(32'h20));
            @(negedge clk);
            chk($sformatf("blk%0d_grant_next", b), 64'(bus_busy_out), 64'd1);
            run_xfer(0, len, fs, dk, busy, sw, sr, dout);
            set_ch(0, 1'b0, 1'b0, 32'h20, 32'h0);
            @(negedge clk);
        end

        // Reset during XFER: abandoned silently, pointer back so channel 0 wins first.
        ack_dly = 255;
        set_ch(2, 1'b1, 1'b0, 32'h500, 32'h0);
        n_done = 0;
        for (int k = 0; k < 10 && n_done == 0; k++) begin
            @(negedge clk);
            if (read_q) n_done = 1;
        end
        chk("rstmid_strobe_seen", 64'(n_done), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_outputs", outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ack_dly = 0;
        set_ch(0, 1'b1, 1'b0, 32'h20, 32'h0);
        push_exp(0, 1'b0, bus_fn(32'h20));
        push_exp(2, 1'b0, bus_fn(32'h500));
        run_xfer(0, len, fs, dk, busy, sw, sr, dout);
        set_ch(0, 1'b0, 1'b0, 32'h20, 32'h0);
        run_xfer(2, len, fs, dk, busy, sw, sr, dout);
        set_ch(2, 1'b0, 1'b0, 32'h500, 32'h0);
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_cell_bus_arbiter.md
Name: multi_cell_bus_arbiter

Overview:
- Parametrised successor to the single-cell bridge/bus access path.
- Arbitrates N_CH CPU-cell request channels onto one shared external read/write bus with the read_q/write_q/read_dn/write_dn handshake.
- Adds round-robin fairness, a per-transfer timeout with an error flag, and a halt hold-off.
- Sits between the cell array and the daisy-chained memory bus. External outputs are zero when the block does not own the bus, so they can be wired-OR with other masters.

Parameters:
- N_CH, 4, number of request channels (2..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles waiting for read_dn/write_dn; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- ch_read_q  in  N_CH  per-channel read request, held until ch_dn.
- ch_write_q  in  N_CH  per-channel write request, held until ch_dn.
- ch_addr  in  N_CH*ADDR_W  per-channel address, packed; channel i is at bits [i*ADDR_W +: ADDR_W].
- ch_wdata  in  N_CH*DATA_W  per-channel write data, packed the same way.
- ch_dn  out  N_CH  one-hot, one-cycle completion pulse.
- ch_err  out  N_CH  one-cycle timeout flag, coincident with ch_dn.
- ch_rdata  out  DATA_W  read data, valid while ch_dn is high for a read.
- halt_q_in  in  1  global halt; blocks new grants only.
- bus_busy_in  in  1  another master owns the bus.
- bus_busy_out  out  1  this block owns the bus.
- addr_out  out  ADDR_W  bus address; zero when not owner.
- data_out  out  DATA_W  bus write data; zero when not owner or when reading.
- data_in  in  DATA_W  bus read data.
- read_q  out  1  bus read strobe.
- write_q  out  1  bus write strobe.
- read_dn  in  1  read acknowledge.
- write_dn  in  1  write acknowledge.

Behaviour:
- Reset (synchronous, active-high): all outputs are 0 at the first edge with rst=1. State returns to IDLE, the round-robin pointer is set to N_CH-1 (channel 0 wins first), and the timeout counter is cleared.
- Reset mid-transfer abandons the transfer. No ch_dn is emitted.
- FSM states: IDLE, GRANT, XFER, DONE.
- IDLE:
  - If any request is set and bus_busy_in=0 and halt_q_in=0, go to GRANT.
  - The winner is the first requesting channel after the pointer, searching upward with wrap-around.
- GRANT (1 cycle):
  - Latch channel index, address and write data.
  - Operation: write if ch_write_q is set, otherwise read. If both are set, the write is done first and the read is served at a later grant.
  - Assert bus_busy_out. Go to XFER.
- XFER:
  - Drive addr_out, plus data_out for writes. Hold read_q or write_q high.
  - On the matching read_dn or write_dn, capture data_in for reads and go to DONE.
  - The non-matching acknowledge is ignored.
  - If the counter reaches TIMEOUT (and TIMEOUT != 0), go to DONE with the error flag set.
- DONE (1 cycle):
  - Drop read_q, write_q, addr_out and data_out to 0.
  - Pulse ch_dn[idx], plus ch_err[idx] on timeout. ch_rdata holds the captured data (0 on timeout or write).
  - Update the pointer to idx, deassert bus_busy_out, go to IDLE.
- Latency: a request seen in IDLE at cycle 0 gives GRANT at cycle 1 and read_q/write_q at cycle 2. An acknowledge at cycle k gives ch_dn at cycle k+1. Minimum turnaround is 4 cycles per transfer.
- Acknowledge in the same cycle as timeout expiry: treated as success, with ch_err=0.
- Request withdrawn during XFER: the transfer still completes and ch_dn still pulses.
- halt_q_in or bus_busy_in rising during XFER has no effect on the transfer in progress.
- Back-to-back grants of the same channel are only possible when no other channel is requesting.
- bus_busy_out is high exactly from GRANT through DONE inclusive.

Decomposition:
- Shared package/include: state encodings (ARB_IDLE, ARB_GRANT, ARB_XFER, ARB_DONE), in sizes-style constants alongside the existing width defines, plus an ARB_OP_READ/ARB_OP_WRITE encoding.
- One sub-module, rr_pick: a combinational round-robin priority picker. Inputs are the req vector and the pointer; outputs are grant index and grant-valid. This lets it be verified in isolation.

Test Plan:
- Single read: channel 2 requests addr 0x100, read_dn comes 3 cycles after read_q with data_in 0xDEADBEEF -> read_q is asserted at cycle 2; ch_dn[2] and ch_rdata=0xDEADBEEF occur once at the cycle after the acknowledge; bus_busy_out is high across GRANT..DONE.
- Fairness: all four channels hold requests with immediate acknowledges -> service order is 0,1,2,3,0; no channel gets two grants while others wait.
- Timeout: TIMEOUT=8, write from channel 1 with write_dn never asserted -> write_q is high for exactly 8 cycles, then ch_dn[1]=ch_err[1]=1 for one cycle, outputs return to 0, and the next request is served normally.
- Blocking: bus_busy_in=1 (and separately halt_q_in=1) with channel 0 requesting -> no grant and all outputs 0; after release, grant at the next cycle.
- Read+write on one channel: channel 3 asserts both -> the write is performed first (data_out=ch_wdata), then the read on a later grant; two ch_dn pulses.
- Reset mid-XFER: assert rst while read_q=1 -> all outputs are 0 at the next edge, no ch_dn, and the first grant after reset goes to channel 0.
